munoc_bni_response_arbiter: RTL

- Shares the single backward NoC link of a slave network interface between two response streams: write-response (B) flits and read-data (R) packets.
- Arbitrates only at packet boundaries, giving wormhole-safe locking for multi-flit R packets.
- Weighted priority: R is favoured, but B is guaranteed service after R_WEIGHT consecutive R packets.
- Sits between the B/R response FIFOs and the backward-link packetizer; drives one registered flit stage.

---
 rtl/munoc_bni_response_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/munoc_bni_response_arbiter.sv
// rtl/munoc_bni_response_arbiter.sv - B/R response arbiter driving the backward NoC link
//
// Shares one backward link between write-response (B) flits and read-data
// (R) packets. Arbitration happens only at packet boundaries, so an R packet
// is never interleaved with a B flit. R is preferred, but after R_WEIGHT
// consecutive R packets granted while B waits, B wins the next boundary.
//
// Optional statistics: define MUNOC_BNI_RESPONSE_ARBITER_STATS_EN to build
// the counters. Without it, the stat outputs read 0 and stat_clear is ignored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   b_valid/b_data       B flit from the write-response FIFO
//   b_ready              B flit accepted this cycle
//   r_valid/r_data/r_last R flit from the read-data FIFO, r_last marks the tail
//   r_ready              R flit accepted this cycle
//   out_valid/out_data/out_last  registered link flit; out_data MSB = source (1=R)
//   out_ready            link accepts the flit
//   stat_clear           clears the statistics counters
//   stat_b_count         B flits sent (saturating)
//   stat_r_pkt_count     R packets sent (saturating)
`timescale 1ns/1ps
module munoc_bni_response_arbiter #(
  parameter int BW_B_PAYLOAD = 16,
  parameter int BW_R_PAYLOAD = 64,
  parameter int R_WEIGHT     = 2,
  parameter int BW_WCNT      = 4,
  localparam int BW_PAY      = (BW_B_PAYLOAD > BW_R_PAYLOAD) ? BW_B_PAYLOAD : BW_R_PAYLOAD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    b_valid,
  input  logic [BW_B_PAYLOAD-1:0] b_data,
  output logic                    b_ready,
  input  logic                    r_valid,
  input  logic [BW_R_PAYLOAD-1:0] r_data,
  input  logic                    r_last,
  output logic                    r_ready,
  output logic                    out_valid,
  output logic [BW_PAY:0]         out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  input  logic                    stat_clear,
  output logic [15:0]             stat_b_count,
  output logic [15:0]             stat_r_pkt_count
);

  localparam logic [BW_WCNT-1:0] WCNT_MAX = BW_WCNT'(R_WEIGHT);

  typedef enum logic {
    IDLE = 1'b0,
    RPKT = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BW_WCNT-1:0] wcnt_q;
  logic               slot_free;
  logic               b_win;
  logic               b_hs;
  logic               r_hs;

  // The output stage can take a new flit when it is empty or being drained.
  assign slot_free = ~out_valid | out_ready;

  // B wins a boundary when R is absent or R has used up its weight.
  assign b_win = b_valid & (~r_valid | (wcnt_q == WCNT_MAX));

  assign b_hs = b_valid & b_ready;
  assign r_hs = r_valid & r_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a multi-flit R packet locks the link until its tail.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (r_hs && !r_last) state_d = RPKT;
      RPKT: if (r_hs && r_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: at most one ready is ever asserted.
  always_comb begin
    b_ready = 1'b0;
    r_ready = 1'b0;
    if (!rst && slot_free) begin
      case (state_q)
        IDLE: begin
          b_ready = b_win;
          r_ready = r_valid & ~b_win;
        end
        RPKT: r_ready = r_valid;
        default: begin
          b_ready = 1'b0;
          r_ready = 1'b0;
        end
      endcase
    end
  end

  // Weight counter: counts R packets started while B was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if (b_hs) begin
      wcnt_q <= '0;
    end else if (r_hs && (state_q == IDLE) && b_valid && (wcnt_q != WCNT_MAX)) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // Registered flit stage; payload is held while the link stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (b_hs) begin
      out_valid <= 1'b1;
      out_data  <= {1'b0, BW_PAY'(b_data)};
      out_last  <= 1'b1;
    end else if (r_hs) begin
      out_valid <= 1'b1;
      out_data  <= {1'b1, BW_PAY'(r_data)};
      out_last  <= r_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUNOC_BNI_RESPONSE_ARBITER_STATS_EN
  logic [15:0] stat_b_q;
  logic [15:0] stat_r_q;

  // Clear dominates a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_b_q <= '0;
      stat_r_q <= '0;
    end else begin
      if (b_hs && (stat_b_q != 16'hFFFF)) stat_b_q <= stat_b_q + 16'd1;
      if (r_hs && r_last && (stat_r_q != 16'hFFFF)) stat_r_q <= stat_r_q + 16'd1;
    end
  end

  assign stat_b_count     = stat_b_q;
  assign stat_r_pkt_count = stat_r_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_b_count      = '0;
  assign stat_r_pkt_count  = '0;
`endif

endmodule
